// File: rtl/complx_pkg.sv
// Shared types and constants for the sequential complex multiplier.
// COMPLX_MUL_ACC_EN widens the result width for multiply-accumulate operation.
package complx_pkg;

  localparam int W = 16;
`ifdef COMPLX_MUL_ACC_EN
  localparam int OW = 2*W + 8;  // room for 128 accumulated full-scale results
`else
  localparam int OW = 2*W + 1;
`endif

  localparam logic COMPLX_MODE_REAL = 1'b0;
  localparam logic COMPLX_MODE_CPLX = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    DONE
  } cmul_state_e;

endpackage

// File: rtl/smul_w.sv
// Combinational W x W signed multiplier with a full-width 2W-bit product.
module smul_w #(
  parameter int W = 16
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/complx_mul_seq.sv
// Sequential complex multiplier: one shared signed multiplier, four product steps.
// Optional COMPLX_MUL_ACC_EN turns the output registers into a complex accumulator (MAC).
module complx_mul_seq #(
  parameter int W  = complx_pkg::W,
  parameter int OW = complx_pkg::OW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 complx_control,
`ifdef COMPLX_MUL_ACC_EN
  input  logic                 acc_clr,
`endif
  input  logic signed [W-1:0]  A_in,
  input  logic signed [W-1:0]  B_in,
  input  logic signed [W-1:0]  iA_in,
  input  logic signed [W-1:0]  iB_in,
  output logic                 busy,
  output logic                 done,
  output logic signed [OW-1:0] re_out,
  output logic signed [OW-1:0] im_out
);
  import complx_pkg::*;

  cmul_state_e state, state_nxt;

  logic signed [W-1:0]    a_q, b_q, ia_q, ib_q;
  logic                   mode_q;
  logic signed [OW-1:0]   acc_re, acc_im;
  logic signed [W-1:0]    mul_a, mul_b;
  logic signed [2*W-1:0]  prod;
  logic signed [OW-1:0]   prod_x;
  logic signed [OW-1:0]   base_re, base_im;

  smul_w #(.W(W)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  assign prod_x = {{(OW-2*W){prod[2*W-1]}}, prod};

`ifdef COMPLX_MUL_ACC_EN
  assign base_re = re_out;
  assign base_im = im_out;
`else
  assign base_re = '0;
  assign base_im = '0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus per-step operand select for the shared multiplier.
  always_comb begin
    state_nxt = state;
    mul_a     = a_q;
    mul_b     = b_q;
    case (state)
      IDLE: if (start) state_nxt = MUL0;
      MUL0: state_nxt = (mode_q == COMPLX_MODE_REAL) ? DONE : MUL1;
      MUL1: begin
        mul_a     = ia_q;
        mul_b     = ib_q;
        state_nxt = MUL2;
      end
      MUL2: begin
        mul_b     = ib_q;
        state_nxt = MUL3;
      end
      MUL3: begin
        mul_a     = ia_q;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      ia_q   <= '0;
      ib_q   <= '0;
      mode_q <= COMPLX_MODE_REAL;
      acc_re <= '0;
      acc_im <= '0;
      re_out <= '0;
      im_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= A_in;
            b_q    <= B_in;
            ia_q   <= iA_in;
            ib_q   <= iB_in;
            mode_q <= complx_control;
            acc_re <= '0;
            acc_im <= '0;
          end
`ifdef COMPLX_MUL_ACC_EN
          if (acc_clr) begin
            re_out <= '0;
            im_out <= '0;
          end
`endif
        end
        MUL0: begin
          acc_re <= prod_x;
          // Real mode finishes here; the imaginary contribution is zero.
          if (mode_q == COMPLX_MODE_REAL) begin
            re_out <= base_re + prod_x;
            im_out <= base_im;
          end
        end
        MUL1: acc_re <= acc_re - prod_x;
        MUL2: acc_im <= prod_x;
        MUL3: begin
          acc_im <= acc_im + prod_x;
          re_out <= base_re + acc_re;
          im_out <= base_im + acc_im + prod_x;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complx_mul_seq.sv
// Directed self-checking bench for complx_mul_seq: latency, results, ignored starts,
// mid-operation reset and, when COMPLX_MUL_ACC_EN is defined, accumulation/clear.
module tb_complx_mul_seq;
  import complx_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 mode = 1'b0;
  logic signed [W-1:0]  a_in = '0, b_in = '0, ia_in = '0, ib_in = '0;
  logic                 busy, done;
  logic signed [OW-1:0] re_out, im_out;
`ifdef COMPLX_MUL_ACC_EN
  logic                 acc_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  complx_mul_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .complx_control (mode),
`ifdef COMPLX_MUL_ACC_EN
    .acc_clr        (acc_clr),
`endif
    .A_in           (a_in),
    .B_in           (b_in),
    .iA_in          (ia_in),
    .iB_in          (ib_in),
    .busy           (busy),
    .done           (done),
    .re_out         (re_out),
    .im_out         (im_out)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Start one operation at cycle 0 and watch cycles 1..12 (bounded).
  task automatic do_op(input string tag, input logic m, input shortint va, input shortint vb,
                       input shortint via, input shortint vib, input bit clr, input bit noise,
                       input int lat, input longint ere, input longint eim);
    int done_cyc = -1;
    int done_cnt = 0;
    int busy_cnt = 0;
    logic signed [63:0] re_at_done = 0, im_at_done = 0;
    @(negedge clk);
    start = 1'b1; mode = m;
    a_in = va; b_in = vb; ia_in = via; ib_in = vib;
`ifdef COMPLX_MUL_ACC_EN
    acc_clr = clr;
`endif
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc   = cyc;
          re_at_done = re_out;
          im_at_done = im_out;
        end
      end
`ifdef COMPLX_MUL_ACC_EN
      acc_clr = 1'b0;
`endif
      if (noise && cyc <= lat) begin
        start = 1'b1;
        mode  = ~m;
        a_in  = W'($urandom); b_in  = W'($urandom);
        ia_in = W'($urandom); ib_in = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, ".lat"},     done_cyc, lat);
    chk({tag, ".busy"},    busy_cnt, lat);
    chk({tag, ".ndone"},   done_cnt, 1);
    chk({tag, ".re"},      re_at_done, ere);
    chk({tag, ".im"},      im_at_done, eim);
    chk({tag, ".re_hold"}, re_out, ere);
    chk({tag, ".im_hold"}, im_out, eim);
    if (clr) begin end
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.re",   re_out, 0);
    chk("rst.im",   im_out, 0);
    rst_n = 1'b1;

    do_op("cplx",  COMPLX_MODE_CPLX, 3, 5, 4, -2, 1'b1, 1'b0, 5, 23, 14);
    do_op("real",  COMPLX_MODE_REAL, -7, 6, 123, 123, 1'b1, 1'b0, 2, -42, 0);
    do_op("ext",   COMPLX_MODE_CPLX, -32768, -32768, -32768, 32767, 1'b1, 1'b0, 5,
          64'sd2147450880, 64'sd32768);
    do_op("noise", COMPLX_MODE_CPLX, 3, 5, 4, -2, 1'b1, 1'b1, 5, 23, 14);
    do_op("rnois", COMPLX_MODE_REAL, -7, 6, 123, 123, 1'b1, 1'b1, 2, -42, 0);

    // Reset while in MUL2 (cycle 3) with a nonzero result already held.
    @(negedge clk);
    start = 1'b1; mode = COMPLX_MODE_CPLX;
    a_in = 3; b_in = 5; ia_in = 4; ib_in = -2;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mrst.busy_pre", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst.busy", busy, 0);
    chk("mrst.done", done, 0);
    chk("mrst.re",   re_out, 0);
    chk("mrst.im",   im_out, 0);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("mrst.quiet", dn, 0);

`ifdef COMPLX_MUL_ACC_EN
    do_op("mac1", COMPLX_MODE_CPLX, 3, 5, 4, -2, 1'b0, 1'b0, 5, 23, 14);
    do_op("mac2", COMPLX_MODE_CPLX, 1, 1, 0, 0, 1'b0, 1'b0, 5, 24, 14);
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    chk("clr.re", re_out, 0);
    chk("clr.im", im_out, 0);
    do_op("mac3", COMPLX_MODE_REAL, -7, 6, 0, 0, 1'b0, 1'b0, 2, -42, 0);
    do_op("clrst", COMPLX_MODE_CPLX, 3, 5, 4, -2, 1'b1, 1'b0, 5, 23, 14);
`else
    do_op("ovwr", COMPLX_MODE_CPLX, 1, 1, 0, 0, 1'b0, 1'b0, 5, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
